// File: rtl/regbank_arbiter_pkg.sv
// Shared definitions for the two-port register bank: requester ids, data width and clear value.
package regbank_arbiter_pkg;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_e;

   localparam int          RB_DATA_W    = 8;
   localparam logic [7:0]  RB_CLEAR_VAL = 8'h00;

endpackage

// File: rtl/regbank_arbiter_register8bit.sv
// One 8-bit storage entry with synchronous reset and load enable.
module register8bit
   import regbank_arbiter_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [RB_DATA_W-1:0] d,
   output logic [RB_DATA_W-1:0] q
);

   logic [RB_DATA_W-1:0] data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= RB_CLEAR_VAL;
      end else if (load) begin
         data_q <= d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/regbank_arbiter_rr_arb2.sv
// Combinational two-way round-robin choice; the last-grant pointer is held by the caller.
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic gnt_sel,
   output logic gnt_any
);

   // On a tie the requester that was not served last wins.
   assign gnt_sel = (req0 && req1) ? ~last : req1;
   assign gnt_any = req0 | req1;

endmodule

// File: rtl/regbank_arbiter.sv
// Bank of NREG 8-bit registers shared by two requesters through a registered round-robin arbiter.
module regbank_arbiter
   import regbank_arbiter_pkg::*;
#(
   parameter int NREG   = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [7:0]        wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [7:0]        wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid,
   output logic              rid,
   output logic [7:0]        rdata
);

   req_id_e              last_q, last_d;
   req_id_e              rid_q, rid_d;
   logic                 gnt0_q, gnt0_d;
   logic                 gnt1_q, gnt1_d;
   logic                 rvalid_q, rvalid_d;
   logic [7:0]           rdata_q, rdata_d;

   logic                 gnt_sel, gnt_any, grant_en;
   logic                 sel_we;
   logic [ADDR_W-1:0]    sel_addr;
   logic [7:0]           sel_wdata;
   logic [7:0]           rd_mux;
   logic                 bank_rst;
   logic [NREG-1:0]      load;
   logic [RB_DATA_W-1:0] entry_val [NREG];

   rr_arb2 u_arb (
      .req0    (req0),
      .req1    (req1),
      .last    (last_q),
      .gnt_sel (gnt_sel),
      .gnt_any (gnt_any)
   );

   // A clear cycle suppresses arbitration so requests simply stay pending.
   assign grant_en  = gnt_any & ~clear;
   assign sel_we    = gnt_sel ? we1    : we0;
   assign sel_addr  = gnt_sel ? addr1  : addr0;
   assign sel_wdata = gnt_sel ? wdata1 : wdata0;
   assign bank_rst  = reset | clear;

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_entry
         assign load[gi] = grant_en && sel_we && (sel_addr == ADDR_W'(gi));

         register8bit u_reg (
            .clk   (clk),
            .reset (bank_rst),
            .load  (load[gi]),
            .d     (sel_wdata),
            .q     (entry_val[gi])
         );
      end
   endgenerate

   // Addresses with no backing entry fall through to the clear value.
   always_comb begin
      rd_mux = RB_CLEAR_VAL;
      for (int i = 0; i < NREG; i++) begin
         if (sel_addr == ADDR_W'(i)) begin
            rd_mux = entry_val[i];
         end
      end
   end

   always_comb begin
      last_d   = last_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      rvalid_d = 1'b0;
      rid_d    = rid_q;
      rdata_d  = rdata_q;
      if (grant_en) begin
         last_d = req_id_e'(gnt_sel);
         gnt0_d = ~gnt_sel;
         gnt1_d = gnt_sel;
         if (!sel_we) begin
            rvalid_d = 1'b1;
            rid_d    = req_id_e'(gnt_sel);
            rdata_d  = rd_mux;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q   <= REQ1;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         rvalid_q <= 1'b0;
         rid_q    <= REQ0;
         rdata_q  <= RB_CLEAR_VAL;
      end else begin
         last_q   <= last_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         rvalid_q <= rvalid_d;
         rid_q    <= rid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign gnt0   = gnt0_q;
   assign gnt1   = gnt1_q;
   assign rvalid = rvalid_q;
   assign rid    = rid_q;
   assign rdata  = rdata_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter: vector table plus hand-written clear/reset/NREG=3 sequences.
module tb_regbank_arbiter;

   typedef struct {
      logic       r0, w0;
      logic [1:0] a0;
      logic [7:0] d0;
      logic       r1, w1;
      logic [1:0] a1;
      logic [7:0] d1;
      logic       g0, g1, rv, rid;
      logic [7:0] rd;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1, clear = 1'b0;
   logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [1:0] addr0 = 2'd0, addr1 = 2'd0;
   logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
   logic       gnt0, gnt1, rvalid, rid;
   logic [7:0] rdata;

   logic       b_req0 = 1'b0, b_we0 = 1'b0, b_req1 = 1'b0, b_we1 = 1'b0;
   logic [1:0] b_addr0 = 2'd0, b_addr1 = 2'd0;
   logic [7:0] b_wdata0 = 8'h00, b_wdata1 = 8'h00;
   logic       b_gnt0, b_gnt1, b_rvalid, b_rid;
   logic [7:0] b_rdata;

   int checks = 0;
   int failures = 0;
   vec_t vt [17];

   always #5 clk = ~clk;

   regbank_arbiter #(.NREG(4), .ADDR_W(2)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid(rvalid), .rid(rid), .rdata(rdata)
   );

   regbank_arbiter #(.NREG(3), .ADDR_W(2)) dut3 (
      .clk(clk), .reset(reset), .clear(clear),
      .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
      .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
      .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid(b_rvalid), .rid(b_rid), .rdata(b_rdata)
   );

   function automatic vec_t mk(int r0, int w0, int a0, int d0, int r1, int w1, int a1, int d1,
                               int g0, int g1, int rv, int id, int rd);
      vec_t v;
      v.r0 = r0[0]; v.w0 = w0[0]; v.a0 = a0[1:0]; v.d0 = d0[7:0];
      v.r1 = r1[0]; v.w1 = w1[0]; v.a1 = a1[1:0]; v.d1 = d1[7:0];
      v.g0 = g0[0]; v.g1 = g1[0]; v.rv = rv[0]; v.rid = id[0]; v.rd = rd[7:0];
      return v;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic r0, input logic w0, input logic [1:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [1:0] a1, input logic [7:0] d1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
   endtask

   // act/exp packed as {gnt0, gnt1, rvalid, rid, rdata}
   task automatic chk(input string tag, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got g0=%b g1=%b rv=%b rid=%b rd=%h, want g0=%b g1=%b rv=%b rid=%b rd=%h",
                  tag, act[11], act[10], act[9], act[8], act[7:0],
                  exp[11], exp[10], exp[9], exp[8], exp[7:0]);
      end else begin
         $display("tx %s: g0=%b g1=%b rv=%b rid=%b rd=%h ok",
                  tag, act[11], act[10], act[9], act[8], act[7:0]);
      end
   endtask

   task automatic chk_main(input string tag, input logic g0, input logic g1, input logic rv,
                           input logic id, input logic [7:0] rd);
      chk(tag, {gnt0, gnt1, rvalid, rid, rdata}, {g0, g1, rv, id, rd});
   endtask

   task automatic chk_b(input string tag, input logic g0, input logic rv, input logic [7:0] rd);
      chk(tag, {b_gnt0, b_gnt1, b_rvalid, b_rid, b_rdata}, {g0, 1'b0, rv, 1'b0, rd});
   endtask

   task automatic b_op(input logic w, input logic [1:0] a, input logic [7:0] d);
      b_req0 = 1'b1; b_we0 = w; b_addr0 = a; b_wdata0 = d;
      tick();
      b_req0 = 1'b0;
   endtask

   initial begin
      //               r0 w0 a0 d0     r1 w1 a1 d1     g0 g1 rv id rd
      vt[0]  = mk(1, 0, 0, 'h00,  0, 0, 0, 'h00,  1, 0, 1, 0, 'h00);
      vt[1]  = mk(1, 0, 1, 'h00,  0, 0, 0, 'h00,  1, 0, 1, 0, 'h00);
      vt[2]  = mk(1, 0, 2, 'h00,  0, 0, 0, 'h00,  1, 0, 1, 0, 'h00);
      vt[3]  = mk(1, 0, 3, 'h00,  0, 0, 0, 'h00,  1, 0, 1, 0, 'h00);
      vt[4]  = mk(1, 1, 2, 'hA9,  0, 0, 0, 'h00,  1, 0, 0, 0, 'h00);
      vt[5]  = mk(0, 0, 0, 'h00,  1, 0, 2, 'h00,  0, 1, 1, 1, 'hA9);
      vt[6]  = mk(0, 0, 0, 'h00,  0, 0, 0, 'h00,  0, 0, 0, 1, 'hA9);
      vt[7]  = mk(1, 1, 1, 'h11,  1, 1, 3, 'h33,  1, 0, 0, 1, 'hA9);
      vt[8]  = mk(1, 1, 1, 'h11,  1, 1, 3, 'h33,  0, 1, 0, 1, 'hA9);
      vt[9]  = mk(1, 0, 3, 'h00,  1, 0, 1, 'h00,  1, 0, 1, 0, 'h33);
      vt[10] = mk(1, 0, 3, 'h00,  1, 0, 1, 'h00,  0, 1, 1, 1, 'h11);
      vt[11] = mk(0, 0, 0, 'h00,  1, 1, 0, 'h55,  0, 1, 0, 1, 'h11);
      vt[12] = mk(1, 0, 0, 'h00,  0, 0, 0, 'h00,  1, 0, 1, 0, 'h55);
      vt[13] = mk(1, 1, 0, 'h66,  1, 0, 0, 'h00,  0, 1, 1, 1, 'h55);
      vt[14] = mk(1, 1, 0, 'h66,  0, 0, 0, 'h00,  1, 0, 0, 1, 'h55);
      vt[15] = mk(0, 0, 0, 'h00,  1, 0, 0, 'h00,  0, 1, 1, 1, 'h66);
      vt[16] = mk(1, 0, 2, 'h00,  0, 0, 0, 'h00,  1, 0, 1, 0, 'hA9);

      reset = 1'b1;
      tick();
      tick();
      chk_main("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk_b("reset3", 1'b0, 1'b0, 8'h00);
      reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         set_in(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1);
         tick();
         chk_main($sformatf("vec%0d", i), vt[i].g0, vt[i].g1, vt[i].rv, vt[i].rid, vt[i].rd);
      end

      // clear with req0 pending: no grant, then the held request completes on cleared data
      set_in(1, 1, 2'd1, 8'h07, 0, 0, 2'd0, 8'h00);
      tick();
      chk_main("wr a1", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA9);
      set_in(1, 1, 2'd3, 8'h06, 0, 0, 2'd0, 8'h00);
      tick();
      chk_main("wr a3", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA9);
      set_in(1, 0, 2'd1, 8'h00, 0, 0, 2'd0, 8'h00);
      clear = 1'b1;
      tick();
      chk_main("clear", 1'b0, 1'b0, 1'b0, 1'b0, 8'hA9);
      clear = 1'b0;
      tick();
      chk_main("rd a1 clr", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      set_in(1, 0, 2'd3, 8'h00, 0, 0, 2'd0, 8'h00);
      tick();
      chk_main("rd a3 clr", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

      // clear with both pending must not move the pointer (last grant was 0)
      set_in(1, 0, 2'd1, 8'h00, 1, 0, 2'd3, 8'h00);
      clear = 1'b1;
      tick();
      chk_main("clear both", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      clear = 1'b0;
      tick();
      chk_main("after clr", 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);

      // reset at the same edge as a pending write abandons it
      set_in(1, 1, 2'd0, 8'hAA, 0, 0, 2'd0, 8'h00);
      tick();
      chk_main("wr a0 AA", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      set_in(0, 0, 2'd0, 8'h00, 1, 1, 2'd0, 8'h55);
      reset = 1'b1;
      tick();
      chk_main("rst mid", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      reset = 1'b0;
      set_in(1, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);
      tick();
      chk_main("rd a0 rst", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

      // two continuous requesters alternate starting with requester 0
      set_in(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_in(1, 0, 2'd0, 8'h00, 1, 0, 2'd0, 8'h00);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_main($sformatf("alt%0d", i), (i % 2) == 0, (i % 2) == 1, 1'b1, (i % 2) == 1, 8'h00);
      end
      set_in(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);

      // NREG=3: address 3 has no entry
      b_op(1'b1, 2'd0, 8'h01);
      chk_b("n3 wr0", 1'b1, 1'b0, 8'h00);
      b_op(1'b1, 2'd1, 8'h02);
      b_op(1'b1, 2'd2, 8'h03);
      b_op(1'b0, 2'd2, 8'h00);
      chk_b("n3 rd2", 1'b1, 1'b1, 8'h03);
      b_op(1'b0, 2'd3, 8'h00);
      chk_b("n3 rd3", 1'b1, 1'b1, 8'h00);
      b_op(1'b1, 2'd3, 8'hFF);
      chk_b("n3 wr3", 1'b1, 1'b0, 8'h00);
      b_op(1'b0, 2'd0, 8'h00);
      chk_b("n3 rd0", 1'b1, 1'b1, 8'h01);
      b_op(1'b0, 2'd1, 8'h00);
      chk_b("n3 rd1", 1'b1, 1'b1, 8'h02);
      b_op(1'b0, 2'd2, 8'h00);
      chk_b("n3 rd2b", 1'b1, 1'b1, 8'h03);
      tick();
      chk_b("n3 idle", 1'b0, 1'b0, 8'h03);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
